// File: rtl/sigmoid_arbiter_pkg.sv
// sigmoid_arb_pkg: shared types and constants for the sigmoid arbiter.
//   arb_state_t  - arbiter FSM state encoding
//   FP_ONE_HALF  - IEEE-754 single 0.5, sigmoid(0)
//   RNE          - round-to-nearest-even rounding-mode code
package sigmoid_arb_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
   localparam logic [31:0] FP_ONE_HALF = 32'h3F000000;
   localparam logic [2:0]  RNE         = 3'b000;
endpackage

// File: rtl/sigmoid_arbiter_if.sv
// sigmoid_arbiter_if: requester-side bus of the sigmoid arbiter.
//   req_valid/req_data/req_ready    - operand handshake, one lane per requester
//   resp_valid/resp_data/resp_ready - result handshake, data shared by all lanes
// master = requesters, slave = arbiter.
interface sigmoid_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 32
);
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ-1:0]        resp_valid;
   logic [DATA_W-1:0]         resp_data;
   logic [NUM_REQ-1:0]        resp_ready;

   modport master (output req_valid, req_data, resp_ready,
                   input  req_ready, resp_valid, resp_data);
   modport slave  (input  req_valid, req_data, resp_ready,
                   output req_ready, resp_valid, resp_data);
endinterface

// File: rtl/sigmoid_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req_i - request vector
//   ptr_i - highest-priority index
//   gnt_o - one-hot grant (0 when no request)
//   idx_o - index of the granted bit
//   any_o - at least one request present
module rr_pick #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req_i,
   input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
   output logic [NUM_REQ-1:0]         gnt_o,
   output logic [$clog2(NUM_REQ)-1:0] idx_o,
   output logic                       any_o
);
   localparam int IDX_W = $clog2(NUM_REQ);

   // Scan from farthest to nearest offset so the nearest hit wins.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = |req_i;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req_i[IDX_W'((int'(ptr_i) + k) % NUM_REQ)]) begin
            gnt_o = '0;
            gnt_o[IDX_W'((int'(ptr_i) + k) % NUM_REQ)] = 1'b1;
            idx_o = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
         end
      end
   end
endmodule

// File: rtl/sigmoid_arbiter.sv
// sigmoid_arbiter: shares one fixed-latency sigmoid unit among NUM_REQ
// requesters in round-robin order.
//   clk, rst        - clock, synchronous active-high reset
//   round_mode      - rounding mode, forwarded to sig_round_mode
//   bus (slave)     - requester operand/result handshakes
//   sig_in_x        - operand to the sigmoid unit (held while busy)
//   sig_in_valid    - one-cycle start pulse
//   sig_out         - sigmoid result, valid SIG_LATENCY cycles after start
//   busy            - FSM not in IDLE
//   perf_ops/perf_stall - only with SIGMOID_ARB_PERF_EN defined:
//                     completed operations / cycles a non-granted requester waited
module sigmoid_arbiter
   import sigmoid_arb_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int DATA_W      = 32,
   parameter int SIG_LATENCY = 28
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [2:0]        round_mode,
   sigmoid_arbiter_if.slave  bus,
   output logic [DATA_W-1:0] sig_in_x,
   output logic              sig_in_valid,
   output logic [2:0]        sig_round_mode,
   input  logic [DATA_W-1:0] sig_out,
   output logic              busy
`ifdef SIGMOID_ARB_PERF_EN
   ,
   output logic [31:0]       perf_ops,
   output logic [31:0]       perf_stall
`endif
);
   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(SIG_LATENCY + 1);

   arb_state_t         state_q, state_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]   gnt_q, gnt_d;
   logic [DATA_W-1:0]  op_q, op_d;
   logic [DATA_W-1:0]  res_q, res_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [NUM_REQ-1:0] pick_gnt;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_any;
   logic [DATA_W-1:0]  req_word [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_word
      assign req_word[i] = bus.req_data[i*DATA_W +: DATA_W];
   end

   rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req_i (bus.req_valid),
      .ptr_i (rr_ptr_q),
      .gnt_o (pick_gnt),
      .idx_o (pick_idx),
      .any_o (pick_any)
   );

   always_comb begin
      state_d        = state_q;
      rr_ptr_d       = rr_ptr_q;
      gnt_d          = gnt_q;
      op_d           = op_q;
      res_d          = res_q;
      cnt_d          = cnt_q;
      bus.req_ready  = '0;
      bus.resp_valid = '0;
      bus.resp_data  = '0;
      sig_in_valid   = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               bus.req_ready = pick_gnt;
               gnt_d         = pick_idx;
               op_d          = req_word[pick_idx];
               state_d       = ISSUE;
            end
         end
         ISSUE: begin
            sig_in_valid = 1'b1;
            cnt_d        = CNT_W'(SIG_LATENCY);
            state_d      = WAIT;
         end
         WAIT: begin
            // cnt==1 lands exactly SIG_LATENCY edges after the ISSUE edge.
            if (cnt_q == CNT_W'(1)) begin
               res_d   = sig_out;
               cnt_d   = '0;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RESP: begin
            bus.resp_valid[gnt_q] = 1'b1;
            bus.resp_data         = res_q;
            if (bus.resp_ready[gnt_q]) begin
               rr_ptr_d = (gnt_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_q + IDX_W'(1);
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         gnt_q    <= '0;
         op_q     <= '0;
         res_q    <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         gnt_q    <= gnt_d;
         op_q     <= op_d;
         res_q    <= res_d;
         cnt_q    <= cnt_d;
      end
   end

   // Operand only changes on the grant edge, so it stays stable through WAIT.
   assign sig_in_x       = op_q;
   assign sig_round_mode = round_mode;
   assign busy           = (state_q != IDLE);

`ifdef SIGMOID_ARB_PERF_EN
   logic [31:0] perf_ops_q, perf_stall_q;
   logic        op_done, stall;

   assign op_done = (state_q == RESP) && bus.resp_ready[gnt_q];
   assign stall   = (state_q != IDLE) &&
                    |(bus.req_valid & ~(NUM_REQ'(1) << gnt_q));

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_ops_q   <= '0;
         perf_stall_q <= '0;
      end else begin
         if (op_done && (perf_ops_q != '1))  perf_ops_q   <= perf_ops_q + 32'd1;
         if (stall && (perf_stall_q != '1))  perf_stall_q <= perf_stall_q + 32'd1;
      end
   end

   assign perf_ops   = perf_ops_q;
   assign perf_stall = perf_stall_q;
`endif
endmodule

// File: tb/tb_sigmoid_arbiter.sv
// Bench for sigmoid_arbiter: directed steps, scoreboard of grants vs results,
// and a fixed-latency sigmoid model that drives garbage except in the one
// cycle the arbiter is supposed to sample.
module tb_sigmoid_arbiter;
   import sigmoid_arb_pkg::*;

   localparam int NR = 4;
   localparam int DW = 32;
   localparam int L  = 28;

   logic          clk = 1'b0;
   logic          rst;
   logic [2:0]    round_mode;
   logic [DW-1:0] sig_in_x;
   logic          sig_in_valid;
   logic [2:0]    sig_round_mode;
   logic [DW-1:0] sig_out = '0;
   logic          busy;
   logic [NR-1:0] persist;

   always #5 clk = ~clk;

   sigmoid_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

`ifdef SIGMOID_ARB_PERF_EN
   logic [31:0] perf_ops, perf_stall;
`endif

   sigmoid_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .SIG_LATENCY(L)) dut (
      .clk            (clk),
      .rst            (rst),
      .round_mode     (round_mode),
      .bus            (bus),
      .sig_in_x       (sig_in_x),
      .sig_in_valid   (sig_in_valid),
      .sig_round_mode (sig_round_mode),
      .sig_out        (sig_out),
      .busy           (busy)
`ifdef SIGMOID_ARB_PERF_EN
      ,
      .perf_ops       (perf_ops),
      .perf_stall     (perf_stall)
`endif
   );

   function automatic logic [31:0] sig_f(input logic [31:0] x);
      case (x)
         32'h00000000: return FP_ONE_HALF;
         32'hC0A00000: return 32'h3DAAAAB0;
         32'hBF800000: return 32'h3E800000;
         32'h3F800000: return 32'h3F400000;
         32'h40A00000: return 32'h3F6AAAAA;
         default:      return x ^ 32'h5A5A5A5A;
      endcase
   endfunction

   function automatic logic [DW-1:0] word(input int k);
      return DW'(bus.req_data >> (k * DW));
   endfunction

   int ntests = 0;
   int nfail  = 0;
   int cyc    = 0;
   int ndone  = 0;

   typedef struct { int idx; logic [31:0] val; } exp_t;
   exp_t        sb[$];
   int          glog[$];
   int          gcyc = -100;
   logic        first_pend = 1'b0;
   logic [31:0] cur_op = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) cyc++;

   // Sigmoid model: valid output only in the cycle ending SIG_LATENCY edges
   // after the issue edge; any other sample gets a value that differs.
   int          m_age = 1000;
   logic [31:0] m_x   = '0;
   always @(posedge clk) begin
      if (sig_in_valid) begin
         m_x   = sig_in_x;
         m_age = 0;
      end else if (m_age < 1000) begin
         m_age++;
      end
      #1;
      if (m_age == L - 1) sig_out = sig_f(m_x);
      else                sig_out = sig_f(m_x) ^ ($urandom | 32'd1);
   end

   // Monitor / scoreboard
   always @(negedge clk) begin
      int g;
      if (!rst) begin
         if (bus.req_ready != '0) begin
            chk("req_ready_onehot", 64'($onehot(bus.req_ready)), 64'd1);
            chk("grant_in_idle", 64'(busy), 64'd0);
            g = 0;
            for (int i = 0; i < NR; i++) if (bus.req_ready[i]) g = i;
            sb.push_back('{g, sig_f(word(g))});
            glog.push_back(g);
            gcyc       = cyc;
            first_pend = 1'b1;
            cur_op     = word(g);
         end
         if (sig_in_valid) chk("issue_cycle", 64'(cyc - gcyc), 64'd1);
         if (busy) chk("sig_in_x_stable", 64'(sig_in_x), 64'(cur_op));
         else      chk("idle_quiet", 64'({sig_in_valid, bus.resp_valid}), 64'd0);
         if (bus.resp_valid != '0) begin
            if (first_pend) begin
               chk("latency", 64'(cyc - gcyc), 64'(L + 2));
               first_pend = 1'b0;
            end
            if (sb.size() == 0) begin
               chk("unexpected_resp", 64'(bus.resp_valid), 64'd0);
            end else begin
               chk("resp_route", 64'(bus.resp_valid), 64'(NR'(1) << sb[0].idx));
               chk("resp_data", 64'(bus.resp_data), 64'(sb[0].val));
               if (|(bus.resp_valid & bus.resp_ready)) begin
                  void'(sb.pop_front());
                  ndone++;
               end
            end
         end
      end
   end

   // Requesters drop req_valid after acceptance unless told to persist.
   task automatic tick();
      logic [NR-1:0] acc;
      @(posedge clk);
      acc = bus.req_ready;
      #1;
      bus.req_valid = bus.req_valid & ~(acc & ~persist);
   endtask

   task automatic flush();
      sb.delete();
      glog.delete();
      first_pend = 1'b0;
      cur_op     = '0;
   endtask

   task automatic do_reset();
      rst           = 1'b1;
      bus.req_valid = '0;
      persist       = '0;
      tick();
      tick();
      rst = 1'b0;
      flush();
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int n = 0;
      while ((sb.size() != 0 || busy || bus.req_valid != '0) && n < budget) begin
         tick();
         n++;
      end
      chk({tag, "_timeout"}, 64'(n < budget), 64'd1);
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'd0);
      chk({tag, "_resp_valid"}, 64'(bus.resp_valid), 64'd0);
      chk({tag, "_resp_data"}, 64'(bus.resp_data), 64'd0);
      chk({tag, "_sig_in_x"}, 64'(sig_in_x), 64'd0);
      chk({tag, "_sig_in_valid"}, 64'(sig_in_valid), 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int n, d0, exp_g;
      rst            = 1'b1;
      round_mode     = RNE;
      persist        = '0;
      bus.req_valid  = '0;
      bus.req_data   = '0;
      bus.resp_ready = '1;
      do_reset();

      // Reset state
      chk_outputs_zero("reset");
      chk("round_fwd_rne", 64'(sig_round_mode), 64'(RNE));

      // 1: single request from requester 0
      bus.req_data  = {32'h0, 32'h0, 32'h0, 32'h00000000};
      bus.req_valid = 4'b0001;
      d0 = ndone;
      wait_idle(100, "t1");
      chk("t1_grant_cnt", 64'(glog.size()), 64'd1);
      chk("t1_grant0", 64'((glog.size() > 0) ? glog[0] : -1), 64'd0);
      chk("t1_done", 64'(ndone - d0), 64'd1);

      // 2: all four at once, expected order 0,1,2,3
      do_reset();
      round_mode    = 3'b011;
      bus.req_data  = {32'h40A00000, 32'h3F800000, 32'hBF800000, 32'hC0A00000};
      bus.req_valid = 4'b1111;
      d0 = ndone;
      tick();
      chk("round_fwd", 64'(sig_round_mode), 64'd3);
      wait_idle(300, "t2");
      chk("t2_done", 64'(ndone - d0), 64'd4);
      for (int k = 0; k < 4; k++)
         chk("t2_order", 64'((k < glog.size()) ? glog[k] : -1), 64'(k));
      round_mode = RNE;

      // 3: requesters 1 and 3 continuously valid
      do_reset();
      bus.req_data  = {32'h40A00000, 32'h0, 32'hBF800000, 32'h0};
      persist       = 4'b1010;
      bus.req_valid = 4'b1010;
      n = 0;
      while (glog.size() < 4 && n < 400) begin
         tick();
         n++;
      end
      persist       = '0;
      bus.req_valid = '0;
      wait_idle(100, "t3");
      chk("t3_grant_cnt", 64'(glog.size()), 64'd4);
      for (int k = 0; k < 4; k++) begin
         exp_g = (k % 2 == 0) ? 1 : 3;
         chk("t3_order", 64'((k < glog.size()) ? glog[k] : -1), 64'(exp_g));
      end

      // 4: backpressure on requester 2, other ready bits high
      do_reset();
      bus.resp_ready = 4'b1011;
      bus.req_data   = {32'h0, 32'h3F800000, 32'h0, 32'h0};
      bus.req_valid  = 4'b0100;
      n = 0;
      while (!bus.resp_valid[2] && n < 100) begin
         tick();
         n++;
      end
      chk("t4_reach_resp", 64'(n < 100), 64'd1);
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("t4_resp_valid", 64'(bus.resp_valid), 64'h4);
         chk("t4_resp_data", 64'(bus.resp_data), 64'h3F400000);
         chk("t4_no_issue", 64'(sig_in_valid), 64'd0);
         chk("t4_busy", 64'(busy), 64'd1);
      end
      bus.resp_ready = '1;
      wait_idle(20, "t4");

      // 5: reset while cnt==10 in WAIT
      do_reset();
      bus.req_data  = {32'h0, 32'hBF800000, 32'h3F800000, 32'h0};
      bus.req_valid = 4'b0100;
      n = 0;
      while (glog.size() == 0 && n < 20) begin
         tick();
         n++;
      end
      chk("t5_granted", 64'(glog.size()), 64'd1);
      while (cyc < gcyc + 20) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      flush();
      d0 = ndone;
      chk_outputs_zero("t5_abort");
      for (int k = 0; k < L + 10; k++) tick();
      chk("t5_no_stale_resp", 64'(ndone - d0), 64'd0);
      bus.req_valid = 4'b0010;
      wait_idle(100, "t5");
      chk("t5_fresh_done", 64'(ndone - d0), 64'd1);

      // 6: garbage on sig_out except at the sampling edge
      do_reset();
      bus.req_data  = {32'h40A00000, 32'h0, 32'h0, 32'h0};
      bus.req_valid = 4'b1000;
      d0 = ndone;
      wait_idle(100, "t6");
      chk("t6_done", 64'(ndone - d0), 64'd1);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end
endmodule

// File: doc/sigmoid_arbiter.md
Name: sigmoid_arbiter

Overview:
Shares one multicycle sigmoid_approx datapath among NUM_REQ requesters, e.g. neurons of one layer. Requesters are served in round-robin order.
- The arbiter accepts one operand, pulses the unit's in_valid, and holds the operand stable.
- The unit has no out_valid, so the arbiter counts a fixed latency and then captures the result.
- It returns the result to the granted requester with a valid/ready handshake.
- It sits between the neuron accumulators and the activation unit.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
DATA_W, 32, IEEE-754 word width (exp_width + mant_width of the sigmoid unit)
SIG_LATENCY, 28, clock cycles from the sigmoid in_valid cycle to a valid out_sigmoid (>=1)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous, active-high reset
round_mode  input  3  global rounding mode, forwarded unchanged
req_valid  input  NUM_REQ  per-requester operand valid
req_data  input  NUM_REQ*DATA_W  operands, requester i in bits [i*DATA_W +: DATA_W]
req_ready  output  NUM_REQ  one-hot accept pulse
resp_valid  output  NUM_REQ  one-hot result valid
resp_data  output  DATA_W  result, shared by all requesters
resp_ready  input  NUM_REQ  per-requester result accept
sig_in_x  output  DATA_W  operand to the sigmoid unit
sig_in_valid  output  1  single-cycle start pulse
sig_round_mode  output  3  equals round_mode
sig_out  input  DATA_W  out_sigmoid from the sigmoid unit
busy  output  1  high in every state except IDLE

Behaviour:
Reset values: state=IDLE, rr_ptr=0. The following are all 0: req_ready, resp_valid, resp_data, sig_in_x, sig_in_valid, busy, cnt.

FSM states and transitions:
- IDLE: if any req_valid, grant g = first set bit searching upward from rr_ptr with wrap. In that cycle (combinationally from registered state):
  - req_ready[g]=1;
  - at the edge, latch req_data[g] into op_reg and g into gnt;
  - go to ISSUE.
  - If no request, stay in IDLE with all outputs 0.
- ISSUE (1 cycle): sig_in_valid=1; cnt<=SIG_LATENCY; go to WAIT.
- WAIT: sig_in_valid=0 and sig_in_x continues to equal op_reg.
  - On each edge: if cnt==1, res_reg<=sig_out and go to RESP; else cnt<=cnt-1.
  - Net effect: sig_out is sampled exactly SIG_LATENCY edges after the ISSUE edge.
- RESP: resp_valid[gnt]=1, resp_data=res_reg, both held stable.
  - When resp_ready[gnt]=1: rr_ptr<=(gnt+1) mod NUM_REQ, go to IDLE.
  - resp_ready of other requesters is ignored.

Datapath and counter rules:
- sig_in_x = op_reg in every state except IDLE. In IDLE it holds its last value (0 after reset).
- cnt width is $clog2(SIG_LATENCY+1).

Timing:
- Latency from the req_ready cycle to the first resp_valid cycle is SIG_LATENCY+2 cycles.
- Minimum period per operation is SIG_LATENCY+3 cycles (zero-wait resp_ready).

Requester-side rules and boundary conditions:
- Requester rule: req_data must be stable while req_valid=1 and not yet accepted.
- One request per requester is outstanding; a new request may be raised the cycle after acceptance. It is granted only after the current RESP completes.
- Requester i dropping req_valid before grant is legal and is simply skipped.
- Simultaneous requests: exactly one req_ready bit per acceptance, never two.
- rr_ptr wraps from NUM_REQ-1 to 0.
- rst asserted in any state:
  - next cycle is IDLE with reset values;
  - an in-flight result is discarded, no resp_valid is produced;
  - the sigmoid unit's stale output is ignored.
- A single requester that requests continuously is served each period and is never starved by the FSM. Others are still served in round-robin order.

Optional Feature:
SIGMOID_ARB_PERF_EN
- Defined:
  - adds output ports perf_ops (32) and perf_stall (32);
  - perf_ops increments on each RESP completion;
  - perf_stall increments in every cycle where state==IDLE is false and a non-granted req_valid is high;
  - both saturate at all-ones and clear on rst.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
Shared package sigmoid_arb_pkg:
- typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
- localparam FP_ONE_HALF = 32'h3F000000 (used by benches);
- round-mode constant RNE = 3'b000.

Sub-module rr_pick (NUM_REQ): combinational round-robin priority picker. Takes req vector and rr_ptr, returns one-hot grant plus index.

Test Plan:
1. Single request: requester 0 sends 0x00000000, model returns 0x3F000000 at SIG_LATENCY. Expect:
   - req_ready[0] in cycle T;
   - sig_in_valid only in cycle T+1;
   - resp_valid[0] with resp_data 0x3F000000 from T+30 (SIG_LATENCY=28).
2. All four requesters raise req_valid simultaneously with 0xC0A00000, 0xBF800000, 0x3F800000, 0x40A00000. Expect:
   - grants in order 0,1,2,3;
   - results 0x3DAAAAB0, 0x3E800000, 0x3F400000, 0x3F6AAAAA each routed to the matching resp_valid bit.
3. Round-robin fairness: requesters 1 and 3 held valid continuously from reset. Expect grants alternating 1,3,1,3 and no grant to 0 or 2.
4. Backpressure: hold resp_ready[2] low 10 cycles in RESP. Expect:
   - resp_valid[2] and resp_data unchanged throughout;
   - no new sig_in_valid pulse;
   - busy=1.
5. Reset mid-operation: assert rst for 1 cycle at cnt==10 in WAIT. Expect:
   - next cycle IDLE with all outputs 0;
   - no resp_valid pulse for the aborted request;
   - a fresh request is then serviced with normal latency.
6. Changing sig_out during WAIT: model drives garbage until exactly SIG_LATENCY cycles after the issue. Expect:
   - only the value at that edge is captured;
   - sig_in_x stable for all WAIT cycles.
